// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display for the ALU result path: shift buffer, prescaled scan.
// Define SEG7_SCAN_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
    parameter int N        = 4,
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in_data,
    input  logic              in_valid,
    input  logic              clr,
    input  logic              enable,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic [DIGITS-1:0] an,
    output logic              full
);

    localparam int IW = $clog2(DIGITS);
    localparam int FW = $clog2(DIGITS + 1);
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0]     pre_q;
    logic [IW-1:0]     idx_q;
    logic [3:0]        dbuf_q [DIGITS];
    logic [FW-1:0]     fill_q;
    logic [FW-1:0]     fill_d;
    logic              full_q;
    logic [6:0]        seg_q;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_q;
    logic [DIGITS-1:0] an_d;
    logic [3:0]        nib;
    logic              tc;
    logic              lit;
`ifdef SEG7_SCAN_LZB_EN
    logic              nz;
`endif

    // segment order {a,b,c,d,e,f,g}
    function automatic logic [6:0] glyph(input logic [3:0] v);
        unique case (v)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            4'hF: glyph = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        nib        = '0;
        nib[N-1:0] = in_data;
    end

    assign tc = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        fill_d = fill_q;
        if (clr)
            fill_d = '0;
        else if (in_valid && fill_q != FW'(DIGITS))
            fill_d = fill_q + FW'(1);
    end

    always_comb begin
        an_d  = '1;
        seg_d = '0;
        lit   = enable && (int'(idx_q) < int'(fill_q));
`ifdef SEG7_SCAN_LZB_EN
        nz = 1'b0;
        for (int j = 0; j < DIGITS; j++)
            if (j >= int'(idx_q) && j < int'(fill_q) && dbuf_q[j] != 4'h0)
                nz = 1'b1;
        if (idx_q != '0 && !nz)
            lit = 1'b0;
`endif
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph(dbuf_q[idx_q]);
        end
    end

    // scan runs free of enable, clr and in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (tc) begin
            pre_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DIGITS; k++)
                dbuf_q[k] <= '0;
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (clr) begin
                for (int k = 0; k < DIGITS; k++)
                    dbuf_q[k] <= '0;
            end else if (in_valid) begin
                for (int k = DIGITS - 1; k > 0; k--)
                    dbuf_q[k] <= dbuf_q[k-1];
                dbuf_q[0] <= nib;
            end
            fill_q <= fill_d;
            full_q <= (fill_d == FW'(DIGITS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= '0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign an   = an_q;
    assign full = full_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle model feeding a scoreboard plus directed
// display checks. Honours SEG7_SCAN_LZB_EN when defined.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic       enable = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       full;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.N(4), .DIGITS(4), .PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .clr(clr), .enable(enable),
        .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]),
        .e(seg[2]), .f(seg[1]), .g(seg[0]),
        .an(an), .full(full)
    );

    always #5 clk = ~clk;

    // model state
    int         m_pre = 0;
    int         m_idx = 0;
    int         m_fill = 0;
    logic [3:0] m_buf [4];
    logic [3:0] m_an = 4'hF;
    logic [6:0] m_seg = '0;
    logic       m_full = 1'b0;
    logic [11:0] sb [$];

    function automatic logic [6:0] gl(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, exp_v);
        end
    endtask

    task automatic tick();
        logic [11:0] ex;
        bit lit;
        bit nz;
        if (!rst_n) begin
            m_pre = 0; m_idx = 0; m_fill = 0;
            for (int k = 0; k < 4; k++) m_buf[k] = '0;
            m_an = 4'hF; m_seg = '0; m_full = 1'b0;
        end else begin
            lit = enable && (m_idx < m_fill);
            nz = 1'b0;
            for (int j = m_idx; j < m_fill; j++)
                if (m_buf[j] != 4'h0) nz = 1'b1;
`ifdef SEG7_SCAN_LZB_EN
            if (m_idx > 0 && !nz) lit = 1'b0;
`endif
            m_an = 4'hF;
            m_seg = '0;
            if (lit) begin
                m_an[m_idx] = 1'b0;
                m_seg = gl(m_buf[m_idx]);
            end
            if (m_pre == 3) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pre++;
            end
            if (clr) begin
                m_fill = 0;
                for (int k = 0; k < 4; k++) m_buf[k] = '0;
            end else if (in_valid) begin
                for (int k = 3; k > 0; k--) m_buf[k] = m_buf[k-1];
                m_buf[0] = in_data;
                if (m_fill < 4) m_fill++;
            end
            m_full = (m_fill == 4);
        end
        sb.push_back({m_an, m_seg, m_full});
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        chk("scan", {an, seg, full}, ex);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // advance to the first cycle of a fresh window showing target
    task automatic wait_fresh(input logic [3:0] target);
        int n = 0;
        while (an === target && n < 40) begin tick(); n++; end
        while (an !== target && n < 40) begin tick(); n++; end
        chk("wait_window", {11'b0, n < 40}, 12'd1);
    endtask

    task automatic load(input logic [3:0] v);
        in_data = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) m_buf[k] = '0;

        ticks(3);
        chk("reset", {an, seg, full}, {4'hF, 7'b0, 1'b0});
        rst_n = 1'b1;

        enable = 1'b1;
        load(4'h3);
        wait_fresh(4'b1110);
        chk("one_d0", {1'b0, an, seg}, {1'b0, 4'b1110, 7'b1111001});
        ticks(4);
        chk("one_d1", {1'b0, an, seg}, {1'b0, 4'b1111, 7'b0});

        load(4'h1); load(4'h2); load(4'h3); load(4'h4);
        chk("full_set", {11'b0, full}, 12'd1);
        wait_fresh(4'b1110);
        chk("scan_d0", {1'b0, an, seg}, {1'b0, 4'b1110, 7'b0110011});
        ticks(3);
        chk("hold_d0", {1'b0, an, seg}, {1'b0, 4'b1110, 7'b0110011});
        tick();
        chk("scan_d1", {1'b0, an, seg}, {1'b0, 4'b1101, 7'b1111001});
        ticks(4);
        chk("scan_d2", {1'b0, an, seg}, {1'b0, 4'b1011, 7'b1101101});
        ticks(4);
        chk("scan_d3", {1'b0, an, seg}, {1'b0, 4'b0111, 7'b0110000});

        in_data = 4'hF; in_valid = 1'b1; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        chk("clr_full", {11'b0, full}, 12'd0);
        tick();
        chk("clr_blank", {1'b0, an, seg}, {1'b0, 4'b1111, 7'b0});
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("no_F", {1'b0, an, seg}, {1'b0, 4'b1111, 7'b0});
        end
        load(4'hA);
        wait_fresh(4'b1110);
        chk("after_clr_A", {1'b0, an, seg}, {1'b0, 4'b1110, 7'b1110111});

        load(4'h9); load(4'h5); load(4'h6); load(4'h7); load(4'h8);
        chk("full_shift", {11'b0, full}, 12'd1);
        ticks(6);
        enable = 1'b0;
        tick();
        chk("disable", {1'b0, an, seg}, {1'b0, 4'b1111, 7'b0});
        ticks(5);
        enable = 1'b1;
        ticks(10);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        load(4'h0); load(4'h0); load(4'h5); load(4'h0);
        wait_fresh(4'b1110);
        chk("lz_d0", {1'b0, an, seg}, {1'b0, 4'b1110, 7'b1111110});
        ticks(4);
        chk("lz_d1", {1'b0, an, seg}, {1'b0, 4'b1101, 7'b1011011});
        ticks(4);
`ifdef SEG7_SCAN_LZB_EN
        chk("lz_d2", {1'b0, an, seg}, {1'b0, 4'b1111, 7'b0});
        ticks(4);
        chk("lz_d3", {1'b0, an, seg}, {1'b0, 4'b1111, 7'b0});
`else
        chk("lz_d2", {1'b0, an, seg}, {1'b0, 4'b1011, 7'b1111110});
        ticks(4);
        chk("lz_d3", {1'b0, an, seg}, {1'b0, 4'b0111, 7'b1111110});
`endif

        ticks(2);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {an, seg, full}, {4'hF, 7'b0, 1'b0});
        tick();
        rst_n = 1'b1;
        ticks(8);
        load(4'hC);
        ticks(16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
